// File: rtl/fcc_req_pkg.sv
// fcc_req_pkg: request layout, issue FSM states and acknowledge modes shared by the dispatcher
package fcc_req_pkg;

    localparam int REQ_WIDTH = 264;
    localparam int CH_LSB    = 240;
    localparam int CH_W      = 8;
    localparam int PAYLOAD_W = CH_LSB;

    localparam int CMD_W  = 16;
    localparam int ID_W   = 16;
    localparam int ADDR_W = 48;
    localparam int LEN_W  = 24;
    localparam int DATA_W = 64;
    localparam int CAL_W  = 64;
    localparam int COLN_W = 8;

    localparam int ACK_HANDSHAKE = 0;
    localparam int ACK_LEGACY    = 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_e;

    // Packed MSB-first so that a cast of request bits [239:0] lands each field at its offset
    typedef struct packed {
        logic [COLN_W-1:0] col_num;
        logic [CAL_W-1:0]  col_addr_len;
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [CMD_W-1:0]  cmd;
    } cmd_t;

endpackage

// File: rtl/fcc_req_chan.sv
// fcc_req_chan: one channel's FIFO, command holding register and issue FSM (FCC_REQ_STATS_EN adds event counters)
module fcc_req_chan
    import fcc_req_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ACK_MODE    = ACK_HANDSHAKE,
    parameter int HOLD_CYCLES = 8,
    parameter int AF_MARGIN   = 2,
    localparam int LW         = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  cmd_t          push_cmd_i,
    output logic          full_o,
    output logic          almost_full_o,
    output logic [LW-1:0] level_o,
    output logic          cmd_valid_o,
    input  logic          cmd_ready_i,
    output cmd_t          cmd_o,
    output logic          timeout_o
`ifdef FCC_REQ_STATS_EN
    ,
    output logic [31:0]   issue_cnt_o,
    output logic [31:0]   timeout_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    cmd_t          mem [DEPTH];
    cmd_t          hold_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop;
    logic          empty;

    assign empty         = level_q == '0;
    assign full_o        = level_q == LW'(DEPTH);
    assign level_o       = level_q;
    assign almost_full_o = (DEPTH - int'(level_q)) <= AF_MARGIN;

    // Storage is written only on push; the occupancy count keeps stale entries from being read
    always_ff @(posedge clk)
        if (push_i) mem[wr_ptr_q] <= push_cmd_i;

    // Pointers wrap modulo DEPTH; a push and pop in the same cycle leave the level unchanged
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(push_i) - LW'(pop);
        end

    // The holding register takes the FIFO head whenever the FSM pops it
    always_ff @(posedge clk or posedge rst)
        if (rst) hold_q <= '0;
        else if (pop) hold_q <= mem[rd_ptr_q];

    // Issue FSM state and hold-timeout counter
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end

    // Next state: legacy mode pops only when the controller is ready and re-issues after a timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        if (ACK_MODE == ACK_LEGACY) begin
            case (state_q)
                IDLE: if (cmd_ready_i && !empty) begin
                    pop     = 1'b1;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
                ISSUE: if (!cmd_ready_i) state_d = IDLE;
                    else if (cnt_q == CW'(HOLD_CYCLES - 1)) state_d = GAP;
                    else cnt_d = cnt_q + CW'(1);
                GAP: begin
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
                ISSUE: if (cmd_ready_i) begin
                    pop     = !empty;
                    state_d = empty ? IDLE : ISSUE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs come straight from the state and the holding register
    always_comb begin
        cmd_valid_o = state_q == ISSUE;
        timeout_o   = ACK_MODE == ACK_LEGACY && state_q == GAP;
        cmd_o       = hold_q;
    end

`ifdef FCC_REQ_STATS_EN
    logic [31:0] issue_cnt_q, timeout_cnt_q;
    logic        accepted;

    assign accepted      = state_q == ISSUE && (ACK_MODE == ACK_LEGACY ? !cmd_ready_i : cmd_ready_i);
    assign issue_cnt_o   = issue_cnt_q;
    assign timeout_cnt_o = timeout_cnt_q;

    // Event counters wrap at 2^32
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            issue_cnt_q   <= '0;
            timeout_cnt_q <= '0;
        end else begin
            issue_cnt_q   <= issue_cnt_q + 32'(accepted);
            timeout_cnt_q <= timeout_cnt_q + 32'(timeout_o);
        end
`endif

endmodule

// File: rtl/fcc_req_dispatch.sv
// fcc_req_dispatch: routes 264-bit requests to per-channel queues and issues commands (FCC_REQ_STATS_EN adds counters)
module fcc_req_dispatch
    import fcc_req_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DEPTH       = 16,
    parameter int ACK_MODE    = ACK_HANDSHAKE,
    parameter int HOLD_CYCLES = 8,
    parameter int AF_MARGIN   = 2,
    localparam int LW         = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [REQ_WIDTH-1:0]       i_req_data,
    output logic                       o_bad_ch,
    output logic [NUM_CH-1:0]          o_almost_full,
    output logic [NUM_CH*LW-1:0]       o_level,
    output logic [NUM_CH-1:0]          o_cmd_valid,
    input  logic [NUM_CH-1:0]          i_cmd_ready,
    output logic [NUM_CH*CMD_W-1:0]    o_cmd,
    output logic [NUM_CH*ID_W-1:0]     o_cmd_id,
    output logic [NUM_CH*ADDR_W-1:0]   o_addr,
    output logic [NUM_CH*LEN_W-1:0]    o_len,
    output logic [NUM_CH*DATA_W-1:0]   o_data,
    output logic [NUM_CH*CAL_W-1:0]    o_col_addr_len,
    output logic [NUM_CH*COLN_W-1:0]   o_col_num,
    output logic [NUM_CH-1:0]          o_timeout
`ifdef FCC_REQ_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]       o_issue_cnt,
    output logic [NUM_CH*32-1:0]       o_timeout_cnt
`endif
);

    logic [CH_W-1:0]   ch;
    logic [NUM_CH-1:0] hit, full;
    logic              bad_ch, bad_q;
    cmd_t              req_cmd;
    logic              unused_req_bits;

    assign ch              = i_req_data[CH_LSB +: CH_W];
    assign bad_ch          = ch >= CH_W'(NUM_CH);
    assign req_cmd         = i_req_data[PAYLOAD_W-1:0];
    assign unused_req_bits = ^i_req_data[REQ_WIDTH-1:CH_LSB+CH_W];
    assign o_req_ready     = bad_ch | |(hit & ~full);
    assign o_bad_ch        = bad_q;

    // Requests for nonexistent channels are swallowed at ingress and flagged one cycle later
    always_ff @(posedge clk or posedge rst)
        if (rst) bad_q <= 1'b0;
        else bad_q <= i_req_valid & bad_ch;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cmd_t cmd;
        assign hit[c] = ch == CH_W'(c);
        fcc_req_chan #(
            .DEPTH(DEPTH),
            .ACK_MODE(ACK_MODE),
            .HOLD_CYCLES(HOLD_CYCLES),
            .AF_MARGIN(AF_MARGIN)
        ) u_chan (
            .clk(clk),
            .rst(rst),
            .push_i(i_req_valid & hit[c] & ~full[c]),
            .push_cmd_i(req_cmd),
            .full_o(full[c]),
            .almost_full_o(o_almost_full[c]),
            .level_o(o_level[c*LW +: LW]),
            .cmd_valid_o(o_cmd_valid[c]),
            .cmd_ready_i(i_cmd_ready[c]),
            .cmd_o(cmd),
            .timeout_o(o_timeout[c])
`ifdef FCC_REQ_STATS_EN
            ,
            .issue_cnt_o(o_issue_cnt[c*32 +: 32]),
            .timeout_cnt_o(o_timeout_cnt[c*32 +: 32])
`endif
        );
        assign o_cmd[c*CMD_W +: CMD_W]           = cmd.cmd;
        assign o_cmd_id[c*ID_W +: ID_W]          = cmd.id;
        assign o_addr[c*ADDR_W +: ADDR_W]        = cmd.addr;
        assign o_len[c*LEN_W +: LEN_W]           = cmd.len;
        assign o_data[c*DATA_W +: DATA_W]        = cmd.data;
        assign o_col_addr_len[c*CAL_W +: CAL_W]  = cmd.col_addr_len;
        assign o_col_num[c*COLN_W +: COLN_W]     = cmd.col_num;
    end

endmodule
